div24_nonrestoring: RTL and testbench

DIV24_NONRESTORING -- requirements
Module: div24_nonrestoring

---
 rtl/div_pkg.sv | 13 +
 rtl/div_addsub.sv | 15 +
 rtl/div24_nonrestoring.sv | 148 ++++++++++++++
 tb/tb_div24_nonrestoring.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the non-restoring divider: default width and FSM encoding.
package div_pkg;

    localparam int unsigned DIV_W = 24;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

endpackage

// File: rtl/div_addsub.sv
// Combinational (W+1)-bit adder/subtractor; ctrl=1 subtracts b via inversion plus carry-in.
module div_addsub
    import div_pkg::*;
#(
    parameter int unsigned W = DIV_W
) (
    input  logic [W:0] a,
    input  logic [W:0] b,
    input  logic       ctrl,
    output logic [W:0] sum_c
);

    assign sum_c = a + (ctrl ? ~b : b) + (W + 1)'(ctrl);

endmodule

// File: rtl/div24_nonrestoring.sv
// Iterative non-restoring unsigned divider, one quotient bit per cycle, with a final
// remainder-correction cycle and a valid/ready handshake on both sides.
module div24_nonrestoring
    import div_pkg::*;
#(
    parameter int unsigned W = DIV_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         div_by_zero
);

    localparam int unsigned CNT_W = (W > 1) ? $clog2(W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

    div_state_e     state_q, state_d;
    logic [W:0]     p_q, p_d;
    logic [W-1:0]   q_q, q_d;
    logic [W-1:0]   d_q, d_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic           in_ready_d, out_valid_d, dbz_d;
    logic [W-1:0]   quotient_d, remainder_d;

    logic [W:0]     p_shift;
    logic [W:0]     add_a, add_b, add_sum_c;
    logic           add_sub;

    assign p_shift = {p_q[W-1:0], q_q[W-1]};

    // Shared adder: shifted step in CALC (sub if P non-negative), plain P+D in FIX.
    always_comb begin
        add_a   = p_shift;
        add_b   = {1'b0, d_q};
        add_sub = ~p_q[W];
        if (state_q == FIX) begin
            add_a   = p_q;
            add_sub = 1'b0;
        end
    end

    div_addsub #(.W(W)) u_addsub (
        .a     (add_a),
        .b     (add_b),
        .ctrl  (add_sub),
        .sum_c (add_sum_c)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        p_d         = p_q;
        q_d         = q_q;
        d_d         = d_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready;
        out_valid_d = out_valid;
        quotient_d  = quotient;
        remainder_d = remainder;
        dbz_d       = div_by_zero;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    in_ready_d = 1'b0;
                    if (divisor == '0) begin
                        state_d     = DONE;
                        quotient_d  = '1;
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                        out_valid_d = 1'b1;
                    end else begin
                        state_d = CALC;
                        p_d     = '0;
                        q_d     = dividend;
                        d_d     = divisor;
                        cnt_d   = '0;
                        dbz_d   = 1'b0;
                    end
                end
            end
            CALC: begin
                p_d   = add_sum_c;
                q_d   = {q_q[W-2:0], ~add_sum_c[W]};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = FIX;
                    cnt_d   = '0;
                end
            end
            FIX: begin
                p_d         = p_q[W] ? add_sum_c : p_q;
                state_d     = DONE;
                quotient_d  = q_q;
                remainder_d = p_q[W] ? add_sum_c[W-1:0] : p_q[W-1:0];
                out_valid_d = 1'b1;
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset wins over any handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            p_q         <= '0;
            q_q         <= '0;
            d_q         <= '0;
            cnt_q       <= '0;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state_q     <= state_d;
            p_q         <= p_d;
            q_q         <= q_d;
            d_q         <= d_d;
            cnt_q       <= cnt_d;
            in_ready    <= in_ready_d;
            out_valid   <= out_valid_d;
            quotient    <= quotient_d;
            remainder   <= remainder_d;
            div_by_zero <= dbz_d;
        end
    end

endmodule

// File: tb/tb_div24_nonrestoring.sv
// Directed bench for div24_nonrestoring: latency, boundary operands, divide-by-zero,
// back-pressure, mid-operation reset, and a randomized sweep against integer division.
module tb_div24_nonrestoring;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] dividend;
    logic [23:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] quotient;
    logic [23:0] remainder;
    logic        div_by_zero;

    int n_vec = 0;
    int n_err = 0;

    div24_nonrestoring #(.W(24)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offer an operation once in_ready is up; scramble operands right after the accept edge.
    task automatic send(input logic [23:0] a, input logic [23:0] b);
        int g = 0;
        @(negedge clk);
        while (!in_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        chk("in_ready_wait", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dividend = 24'($urandom);
        divisor  = 24'($urandom);
    endtask

    // Counts cycles after the accept edge until out_valid is seen (cycle 1 = first after accept).
    task automatic wait_out(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 200);
        chk("out_valid_seen", 32'(out_valid), 32'd1);
    endtask

    task automatic retire();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [23:0] a, input logic [23:0] b,
                          input logic [23:0] eq, input logic [23:0] er, input logic ez,
                          input int elat);
        int lat;
        send(a, b);
        wait_out(lat);
        chk({tag, "_lat"}, 32'(lat), 32'(elat));
        chk({tag, "_q"}, 32'(quotient), 32'(eq));
        chk({tag, "_r"}, 32'(remainder), 32'(er));
        chk({tag, "_dbz"}, 32'(div_by_zero), 32'(ez));
        retire();
    endtask

    initial begin
        int lat;
        int ov_seen;
        logic [23:0] a, b;
        logic [47:0] prod;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_q", 32'(quotient), 32'd0);
        chk("rst_r", 32'(remainder), 32'd0);
        chk("rst_dbz", 32'(div_by_zero), 32'd0);
        rst = 1'b0;

        run_op("100div7", 24'd100, 24'd7, 24'd14, 24'd2, 1'b0, 26);
        run_op("max_div1", 24'hFFFFFF, 24'd1, 24'hFFFFFF, 24'd0, 1'b0, 26);
        run_op("5div9", 24'd5, 24'd9, 24'd0, 24'd5, 1'b0, 26);
        run_op("max_divmax", 24'hFFFFFF, 24'hFFFFFF, 24'd1, 24'd0, 1'b0, 26);
        run_op("max_div2", 24'hFFFFFF, 24'd2, 24'h7FFFFF, 24'd1, 1'b0, 26);
        run_op("1234div0", 24'd1234, 24'd0, 24'hFFFFFF, 24'd1234, 1'b1, 1);
        run_op("9div3", 24'd9, 24'd3, 24'd3, 24'd0, 1'b0, 26);

        // Hold out_ready low in DONE: results must stay put and no new op may be accepted.
        send(24'd77, 24'd10);
        wait_out(lat);
        in_valid = 1'b1;
        dividend = 24'd1;
        divisor  = 24'd1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_ov", 32'(out_valid), 32'd1);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_q", 32'(quotient), 32'd7);
            chk("stall_r", 32'(remainder), 32'd7);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("retire_in_ready", 32'(in_ready), 32'd1);
        chk("retire_ov", 32'(out_valid), 32'd0);

        // Reset in the middle of CALC aborts the operation silently.
        send(24'd1000, 24'd3);
        repeat (12) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_ov", 32'(out_valid), 32'd0);
        chk("abort_q", 32'(quotient), 32'd0);
        chk("abort_r", 32'(remainder), 32'd0);
        chk("abort_dbz", 32'(div_by_zero), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        ov_seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (out_valid) ov_seen++;
        end
        chk("abort_no_ov", 32'(ov_seen), 32'd0);
        run_op("50div5", 24'd50, 24'd5, 24'd10, 24'd0, 1'b0, 26);

        // Randomized operands with random gaps on both handshakes.
        for (int k = 0; k < 1000; k++) begin
            a = 24'($urandom);
            b = 24'($urandom);
            if (k % 3 == 0) b = 24'($urandom_range(1, 255));
            if (b == 24'd0) b = 24'd1;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send(a, b);
            wait_out(lat);
            chk("rnd_lat", 32'(lat), 32'd26);
            chk("rnd_q", 32'(quotient), 32'(a / b));
            chk("rnd_r", 32'(remainder), 32'(a % b));
            chk("rnd_dbz", 32'(div_by_zero), 32'd0);
            prod = 48'(quotient) * 48'(b) + 48'(remainder);
            chk("rnd_identity", 32'(prod == 48'(a)), 32'd1);
            repeat ($urandom_range(0, 4)) @(negedge clk);
            retire();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
